// File: rtl/audio_i2s_tx_pkg.sv
// Shared constants and types for the synth audio path: sample width, I2S slot
// geometry and the word-select channel encoding.
package audio_i2s_tx_pkg;

    localparam int SAMPLE_W_DEF    = 16;
    localparam int SLOTS_PER_CH    = 32;
    localparam int SLOTS_PER_FRAME = 2 * SLOTS_PER_CH;
    localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock generator: divides clk by 2*BCLK_DIV and flags the clk cycle on
// which bclk is about to rise or fall, so a serialiser can act on the same edge.
module audio_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int                DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = enable && (div_cnt == DIV_LAST);
    assign rise = tick && !bclk;
    assign fall = tick && bclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: captures a left/right sample pair once per 64-slot frame and
// shifts it out MSB first with the standard one-slot delay after each lrclk edge.
module audio_i2s_tx
    import audio_i2s_tx_pkg::*;
#(
    parameter int BCLK_DIV = 4,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] audio_l,
    input  logic [SAMPLE_W-1:0] audio_r,
    output logic                sample_strobe,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_data
);

    localparam int                PAD      = SLOTS_PER_CH - 1 - SAMPLE_W;
    localparam logic [SLOT_W-1:0] LAST_BIT = SLOT_W'(SLOTS_PER_FRAME - 1);

    logic                       bclk;
    logic                       rise_unused;
    logic                       fall;
    logic [SLOT_W-1:0]          bit_cnt;
    logic [SLOT_W-1:0]          bit_next;
    logic [SAMPLE_W-1:0]        shadow_l;
    logic [SAMPLE_W-1:0]        shadow_r;
    logic [SLOTS_PER_CH-1:0]    half_l;
    logic [SLOTS_PER_CH-1:0]    half_r;
    logic [SLOTS_PER_FRAME-1:0] frame;
    channel_t                   ch_next;

    // Rise events are exported for the future receiver; the transmitter only
    // changes state when bclk falls.
    audio_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .bclk    (bclk),
        .rise    (rise_unused),
        .fall    (fall)
    );

    assign i2s_bclk = bclk;

    // Frame image indexed MSB-first by slot: bit 63 is slot 0. Each channel's
    // MSB lands one slot after the lrclk edge, the rest of the channel is 0.
    always_comb begin
        bit_next = bit_cnt + 1'b1;
        ch_next  = channel_t'(bit_next[SLOT_W-1]);
        half_l   = SLOTS_PER_CH'(shadow_l) << PAD;
        half_r   = SLOTS_PER_CH'(shadow_r) << PAD;
        frame    = {half_l, half_r};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt       <= LAST_BIT;
            i2s_lrclk     <= 1'b0;
            i2s_data      <= 1'b0;
            sample_strobe <= 1'b0;
            shadow_l      <= '0;
            shadow_r      <= '0;
        end else if (!enable) begin
            // Shadows survive a pause; the frame itself restarts from slot 0.
            bit_cnt       <= LAST_BIT;
            i2s_lrclk     <= 1'b0;
            i2s_data      <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            if (fall) begin
                bit_cnt   <= bit_next;
                i2s_lrclk <= (ch_next == CH_RIGHT);
                i2s_data  <= frame[~bit_next];
                if (bit_next == '0) begin
                    shadow_l      <= audio_l;
                    shadow_r      <= audio_r;
                    sample_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: stimulus pushes the sample pair each frame
// should carry; a monitor decodes frames from the pins and compares.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] audio_l = '0;
    logic [15:0] audio_r = '0;
    logic        sel = 1'b0;

    logic s2, b2, l2, d2;
    logic s1, b1, l1, d1;
    logic mon_strobe, mon_bclk, mon_lrclk, mon_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    audio_i2s_tx #(.BCLK_DIV(2), .SAMPLE_W(16)) dut_div2 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .audio_l(audio_l), .audio_r(audio_r),
        .sample_strobe(s2), .i2s_bclk(b2), .i2s_lrclk(l2), .i2s_data(d2)
    );

    audio_i2s_tx #(.BCLK_DIV(1), .SAMPLE_W(16)) dut_div1 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .audio_l(audio_l), .audio_r(audio_r),
        .sample_strobe(s1), .i2s_bclk(b1), .i2s_lrclk(l1), .i2s_data(d1)
    );

    assign mon_strobe = sel ? s1 : s2;
    assign mon_bclk   = sel ? b1 : b2;
    assign mon_lrclk  = sel ? l1 : l2;
    assign mon_data   = sel ? d1 : d2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        exp_q.push_back({l, r});
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_strobe(input int max, output int n);
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < max) begin
            @(negedge clk);
            n++;
            got = mon_strobe;
        end
        if (!got) chk("strobe_timeout", 32'd0, 32'd1);
    endtask

    task automatic monitor();
        int   slot = -1;
        int   cyc = 0;
        int   last_strobe = -1;
        int   frame_no = 0;
        logic bclk_prev = 1'b0;
        logic prev_act = 1'b0;
        logic act;
        logic bits[64];
        logic lrs[64];
        logic [15:0] dl, dr;
        logic [31:0] e;
        logic zok, lok;
        forever begin
            @(negedge clk);
            cyc++;
            act = reset_n && enable;
            if (!act) begin
                if (prev_act) exp_q.delete();
                slot = -1;
                last_strobe = -1;
                bclk_prev = 1'b0;
            end else begin
                if (mon_bclk && !bclk_prev && slot >= 0) begin
                    bits[slot] = mon_data;
                    lrs[slot]  = mon_lrclk;
                    slot++;
                    if (slot == 64) begin
                        slot = -1;
                        for (int i = 1; i <= 16; i++) begin
                            dl[16-i] = bits[i];
                            dr[16-i] = bits[32+i];
                        end
                        zok = !bits[0];
                        for (int i = 17; i <= 32; i++) if (bits[i]) zok = 1'b0;
                        for (int i = 49; i <= 63; i++) if (bits[i]) zok = 1'b0;
                        lok = 1'b1;
                        for (int i = 0; i < 64; i++) if (lrs[i] !== (i >= 32)) lok = 1'b0;
                        $display("frame %0d div=%0d L=%h R=%h", frame_no, sel ? 1 : 2, dl, dr);
                        frame_no++;
                        if (exp_q.size() == 0) begin
                            chk("frame_unexpected", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_left", {16'h0, dl}, {16'h0, e[31:16]});
                            chk("frame_right", {16'h0, dr}, {16'h0, e[15:0]});
                            chk("frame_zero_slots", {31'h0, zok}, 32'd1);
                            chk("frame_lrclk", {31'h0, lok}, 32'd1);
                        end
                    end
                end
                if (mon_strobe) begin
                    if (last_strobe >= 0)
                        chk("strobe_spacing", cyc - last_strobe, sel ? 32'd128 : 32'd256);
                    last_strobe = cyc;
                    slot = 0;
                end
                bclk_prev = mon_bclk;
            end
            prev_act = act;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  toggles;
        logic pb;
        logic idle_ok;

        fork
            monitor();
        join_none

        wait_clks(3);
        chk("reset_state", {28'h0, s1, b1, l1, d1, s2, b2, l2, d2} , 32'd0);

        // Basic frame; first strobe 2*BCLK_DIV clks after release.
        audio_l = 16'hA5F0;
        audio_r = 16'h1234;
        push_frame(16'hA5F0, 16'h1234);
        enable  = 1'b1;
        reset_n = 1'b1;
        wait_strobe(50, n);
        chk("first_strobe_clks", n, 32'd4);

        // Mid-frame input change only affects the next frame.
        wait_clks(40);
        audio_l = 16'h0001;
        push_frame(16'h0001, 16'h1234);
        wait_strobe(600, n);

        wait_clks(40);
        audio_l = 16'h8000;
        audio_r = 16'hFFFF;
        push_frame(16'h8000, 16'hFFFF);
        wait_strobe(600, n);

        // Pause at slot 40, then restart from slot 0.
        wait_clks(160);
        chk("pre_pause_lrclk", {31'h0, mon_lrclk}, 32'd1);
        enable = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({mon_bclk, mon_lrclk, mon_data, mon_strobe} !== 4'b0) idle_ok = 1'b0;
        end
        chk("pause_idle", {31'h0, idle_ok}, 32'd1);
        enable = 1'b1;
        push_frame(16'h8000, 16'hFFFF);
        wait_strobe(50, n);
        chk("reenable_strobe_clks", n, 32'd4);
        wait_strobe(600, n);

        // Asynchronous reset in the right channel.
        wait_clks(166);
        chk("pre_reset_lrclk", {31'h0, mon_lrclk}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {28'h0, mon_bclk, mon_lrclk, mon_data, mon_strobe}, 32'd0);
        audio_l = 16'h0F0F;
        audio_r = 16'hF0F0;
        wait_clks(3);
        reset_n = 1'b1;
        push_frame(16'h0F0F, 16'hF0F0);
        wait_strobe(50, n);
        chk("post_reset_strobe_clks", n, 32'd4);
        wait_strobe(600, n);

        // Switch the monitor to the BCLK_DIV=1 instance.
        reset_n = 1'b0;
        sel     = 1'b1;
        audio_l = 16'h5A5A;
        audio_r = 16'hC3C3;
        wait_clks(2);
        reset_n = 1'b1;
        push_frame(16'h5A5A, 16'hC3C3);
        wait_strobe(50, n);
        chk("div1_first_strobe_clks", n, 32'd2);
        pb = mon_bclk;
        toggles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mon_bclk !== pb) toggles++;
            pb = mon_bclk;
        end
        chk("div1_bclk_toggles", toggles, 32'd8);
        push_frame(16'h5A5A, 16'hC3C3);
        wait_strobe(300, n);
        wait_strobe(300, n);
        wait_clks(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
